// File: rtl/alpaca_capture_pkg.sv
// Shared types and default geometry for the AXIS frame capture block.
// Module-specific widths are re-derived from each instance's parameters.
package alpaca_capture_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE, DONE} capture_state_t;
  typedef enum logic {ONESHOT, RING} capture_mode_t;

  localparam int DEF_FRAME_LEN = 512;
  localparam int DEF_FRAMES    = 32;
  localparam int DEF_SAMP_W    = $clog2(DEF_FRAME_LEN);
  localparam int DEF_FIDX_W    = $clog2(DEF_FRAMES);
  localparam int DEF_ADDR_W    = DEF_SAMP_W + DEF_FIDX_W;
  localparam int DEF_CNT_W     = DEF_FIDX_W + 1;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/capture_sdp_ram.sv
// Simple dual-port sample store: one write port, registered read-first read port.
// Only the output register is reset; the array itself maps onto block RAM.
module capture_sdp_ram
  import alpaca_capture_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Separate non-blocking read sees the pre-write contents on an address collision.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/axis_frame_capture.sv
// Passive frame-aligned AXIS capture into on-chip RAM with one-shot/ring modes,
// frame decimation and tlast integrity counting.
module axis_frame_capture
  import alpaca_capture_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAME_LEN = 512,
  parameter int FRAMES    = 32,
  parameter int SKIP_W    = 8,
  parameter int ERR_W     = 16
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  arm,
  input  logic                                  stop,
  input  logic                                  mode,
  input  logic [SKIP_W-1:0]                     skip,
  input  logic [WIDTH-1:0]                      s_axis_tdata,
  input  logic                                  s_axis_tvalid,
  input  logic                                  s_axis_tlast,
  output logic                                  s_axis_tready,
  input  logic                                  rd_en,
  input  logic [$clog2(FRAMES*FRAME_LEN)-1:0]   rd_addr,
  output logic [WIDTH-1:0]                      rd_data,
  output logic                                  armed,
  output logic                                  full,
  output logic [$clog2(FRAMES):0]               frames_captured,
  output logic [$clog2(FRAMES)-1:0]             ring_head,
  output logic [ERR_W-1:0]                      tlast_err
);

  localparam int SAMP_W = $clog2(FRAME_LEN);
  localparam int FIDX_W = $clog2(FRAMES);
  localparam int ADDR_W = SAMP_W + FIDX_W;
  localparam int CNT_W  = FIDX_W + 1;

  localparam logic [SAMP_W-1:0] LAST_SAMP  = SAMP_W'(FRAME_LEN - 1);
  localparam logic [FIDX_W-1:0] LAST_FRAME = FIDX_W'(FRAMES - 1);
  localparam logic [CNT_W-1:0]  FRAMES_CNT = CNT_W'(FRAMES);
  localparam logic [ERR_W-1:0]  ERR_MAX    = '1;

  capture_state_t     state_reg;
  capture_mode_t      mode_reg;
  logic [SKIP_W-1:0]  skip_reg;
  logic [SKIP_W-1:0]  skip_cnt_reg;
  logic [SAMP_W-1:0]  samp_idx_reg;
  logic [FIDX_W-1:0]  frame_idx_reg;
  logic [CNT_W-1:0]   frames_captured_reg;
  logic               full_reg;
  logic [ERR_W-1:0]   tlast_err_reg;
  logic               stop_pend_reg;

  logic beat;
  logic at_last;
  logic write_frame;
  logic normal_end;
  logic bad_end;
  logic stop_now;
  logic wr_en;

  assign beat        = s_axis_tvalid;
  assign at_last     = (samp_idx_reg == LAST_SAMP);
  assign write_frame = (skip_cnt_reg == '0);
  assign normal_end  = beat && at_last && s_axis_tlast;
  // Covers both a missing tlast on the last sample and an early tlast.
  assign bad_end     = beat && (at_last != s_axis_tlast);
  assign stop_now    = stop_pend_reg || stop;
  assign wr_en       = (state_reg == CAPTURE) && beat && write_frame && !arm;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg           <= IDLE;
      mode_reg            <= ONESHOT;
      skip_reg            <= '0;
      skip_cnt_reg        <= '0;
      samp_idx_reg        <= '0;
      frame_idx_reg       <= '0;
      frames_captured_reg <= '0;
      full_reg            <= 1'b0;
      tlast_err_reg       <= '0;
      stop_pend_reg       <= 1'b0;
    end else if (arm) begin
      state_reg           <= SYNC;
      mode_reg            <= capture_mode_t'(mode);
      skip_reg            <= skip;
      skip_cnt_reg        <= '0;
      samp_idx_reg        <= '0;
      frame_idx_reg       <= '0;
      frames_captured_reg <= '0;
      full_reg            <= 1'b0;
      tlast_err_reg       <= '0;
      stop_pend_reg       <= 1'b0;
    end else begin
      case (state_reg)
        SYNC: begin
          if (stop) begin
            state_reg     <= DONE;
            stop_pend_reg <= 1'b0;
          end else if (beat && s_axis_tlast) begin
            state_reg    <= CAPTURE;
            samp_idx_reg <= '0;
          end
        end
        CAPTURE: begin
          if (stop) begin
            stop_pend_reg <= 1'b1;
          end
          if (beat) begin
            samp_idx_reg <= samp_idx_reg + 1'b1;
            if (normal_end) begin
              samp_idx_reg <= '0;
              if (write_frame) begin
                frame_idx_reg <= frame_idx_reg + 1'b1;
                skip_cnt_reg  <= skip_reg;
                if (frames_captured_reg != FRAMES_CNT) begin
                  frames_captured_reg <= frames_captured_reg + 1'b1;
                end
                if (frame_idx_reg == LAST_FRAME) begin
                  full_reg <= 1'b1;
                end
                if (stop_now || (mode_reg == ONESHOT && frame_idx_reg == LAST_FRAME)) begin
                  state_reg     <= DONE;
                  stop_pend_reg <= 1'b0;
                end
              end else begin
                skip_cnt_reg <= skip_cnt_reg - 1'b1;
                if (stop_now) begin
                  state_reg     <= DONE;
                  stop_pend_reg <= 1'b0;
                end
              end
            end else if (bad_end) begin
              samp_idx_reg <= '0;
              if (tlast_err_reg != ERR_MAX) begin
                tlast_err_reg <= tlast_err_reg + 1'b1;
              end
              // An early tlast leaves the stream aligned; a missing one needs resync.
              if (!s_axis_tlast) begin
                state_reg <= SYNC;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  capture_sdp_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_addr ({frame_idx_reg, samp_idx_reg}),
    .wr_data (s_axis_tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign s_axis_tready   = 1'b1;
  assign armed           = (state_reg == SYNC) || (state_reg == CAPTURE);
  assign full            = full_reg;
  assign frames_captured = frames_captured_reg;
  assign ring_head       = frame_idx_reg;
  assign tlast_err       = tlast_err_reg;

endmodule

// File: tb/tb_axis_frame_capture.sv
// Directed bench for axis_frame_capture: FRAME_LEN=8, FRAMES=4, tdata is the running beat count.
module tb_axis_frame_capture;

  localparam int WIDTH     = 32;
  localparam int FRAME_LEN = 8;
  localparam int FRAMES    = 4;
  localparam int SKIP_W    = 8;
  localparam int ERR_W     = 16;
  localparam int ADDR_W    = 5;
  localparam int CNT_W     = 3;
  localparam int FIDX_W    = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              arm;
  logic              stop;
  logic              mode;
  logic [SKIP_W-1:0] skip;
  logic [WIDTH-1:0]  s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              armed;
  logic              full;
  logic [CNT_W-1:0]  frames_captured;
  logic [FIDX_W-1:0] ring_head;
  logic [ERR_W-1:0]  tlast_err;

  int compared   = 0;
  int mismatched = 0;
  int bc         = 0;
  int base;
  int b2;
  int b3;

  axis_frame_capture #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FRAME_LEN),
    .FRAMES    (FRAMES),
    .SKIP_W    (SKIP_W),
    .ERR_W     (ERR_W)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .arm             (arm),
    .stop            (stop),
    .mode            (mode),
    .skip            (skip),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .armed           (armed),
    .full            (full),
    .frames_captured (frames_captured),
    .ring_head       (ring_head),
    .tlast_err       (tlast_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      $error("check %s differs", tag);
    end
  endtask

  task automatic beat(input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    s_axis_tdata  = WIDTH'(bc);
    bc++;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // n back-to-back beats, tlast only on the final one when last_on_final is set.
  task automatic beats(input int n, input logic last_on_final);
    for (int i = 0; i < n; i++) begin
      beat(last_on_final && (i == n - 1));
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      beats(FRAME_LEN, 1'b1);
    end
  endtask

  task automatic do_arm(input logic m, input int sk, input logic with_stop);
    arm  = 1'b1;
    stop = with_stop;
    mode = m;
    skip = SKIP_W'(sk);
    @(posedge clk);
    #1;
    arm  = 1'b0;
    stop = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
  endtask

  task automatic check_ram(input string tag, input int a, input int exp_v);
    rd_en   = 1'b1;
    rd_addr = ADDR_W'(a);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    $display("read %s addr=%0d data=%0d", tag, a, rd_data);
    check(tag, int'(rd_data), exp_v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; arm = 1'b0; stop = 1'b0; mode = 1'b0; skip = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_armed", int'(armed), 0);
    check("rst_full", int'(full), 0);
    check("rst_fc", int'(frames_captured), 0);
    check("rst_head", int'(ring_head), 0);
    check("rst_err", int'(tlast_err), 0);
    check("rst_rd", int'(rd_data), 0);
    rstn = 1'b1;
    check("tready", int'(s_axis_tready), 1);

    // 1: ONESHOT, skip=0
    do_arm(1'b0, 0, 1'b0);
    check("t1_armed", int'(armed), 1);
    beats(3, 1'b1);          // data 0..2, aligns on the tlast
    beats(31, 1'b0);         // not quite 4 frames; tlast placement below
    // beats above lack internal tlasts, so redo cleanly instead: restart
    do_arm(1'b0, 0, 1'b0);
    beat(1'b1);
    base = bc;
    frames(3);
    beats(7, 1'b0);
    check("t1_full_pre", int'(full), 0);
    check("t1_fc_pre", int'(frames_captured), 3);
    beat(1'b1);
    $display("t1 oneshot done: full=%0d fc=%0d armed=%0d", full, frames_captured, armed);
    check("t1_full", int'(full), 1);
    check("t1_fc", int'(frames_captured), 4);
    check("t1_armed_done", int'(armed), 0);
    check("t1_err", int'(tlast_err), 0);
    frames(1);
    check_ram("t1_ram0", 0, base);
    check_ram("t1_ram5", 5, base + 5);
    check_ram("t1_ram13", 13, base + 13);
    check_ram("t1_ram31", 31, base + 31);

    // 2: RING, 6 frames then stop inside frame 7
    do_arm(1'b1, 0, 1'b0);
    check("t2_full_clr", int'(full), 0);
    beat(1'b1);
    base = bc;
    frames(6);
    check("t2_fc6", int'(frames_captured), 4);
    check("t2_full6", int'(full), 1);
    check("t2_head6", int'(ring_head), 2);
    beats(3, 1'b0);
    pulse_stop();
    check("t2_armed_pend", int'(armed), 1);
    beats(5, 1'b1);
    $display("t2 ring stop: armed=%0d full=%0d head=%0d", armed, full, ring_head);
    check("t2_armed", int'(armed), 0);
    check("t2_full", int'(full), 1);
    check("t2_head", int'(ring_head), 3);
    check_ram("t2_slot0", 0, base + 32);
    check_ram("t2_slot1", 8, base + 40);
    check_ram("t2_slot2", 23, base + 55);

    // 3: ONESHOT with skip=2
    do_arm(1'b0, 2, 1'b0);
    beat(1'b1);
    base = bc;
    frames(9);
    check("t3_fc9", int'(frames_captured), 3);
    check("t3_full9", int'(full), 0);
    frames(1);
    $display("t3 skip: full=%0d fc=%0d armed=%0d", full, frames_captured, armed);
    check("t3_full", int'(full), 1);
    check("t3_fc", int'(frames_captured), 4);
    check("t3_armed", int'(armed), 0);
    check_ram("t3_slot0", 0, base);
    check_ram("t3_slot1", 8, base + 24);
    check_ram("t3_slot2", 17, base + 49);
    check_ram("t3_slot3", 31, base + 79);

    // 4: missing tlast, then early tlast
    do_arm(1'b0, 0, 1'b0);
    beat(1'b1);
    base = bc;
    frames(1);
    beats(8, 1'b0);          // frame 1 with tlast dropped on the 8th beat
    check("t4_err1", int'(tlast_err), 1);
    check("t4_fc1", int'(frames_captured), 1);
    check("t4_head1", int'(ring_head), 1);
    beat(1'b1);              // resync
    b2 = bc;
    frames(1);
    check("t4_fc2", int'(frames_captured), 2);
    beats(5, 1'b1);          // early tlast on beat 5
    $display("t4 early tlast: err=%0d armed=%0d fc=%0d", tlast_err, armed, frames_captured);
    check("t4_err2", int'(tlast_err), 2);
    check("t4_armed", int'(armed), 1);
    check("t4_head2", int'(ring_head), 2);
    b3 = bc;
    frames(1);
    check("t4_fc3", int'(frames_captured), 3);
    check_ram("t4_slot1_0", 8, b2);
    check_ram("t4_slot1_7", 15, b2 + 7);
    check_ram("t4_slot2_0", 16, b3);

    // 5: reset mid-capture
    beats(2, 1'b0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    $display("t5 reset: armed=%0d full=%0d fc=%0d head=%0d err=%0d rd=%0d",
             armed, full, frames_captured, ring_head, tlast_err, rd_data);
    check("t5_armed", int'(armed), 0);
    check("t5_full", int'(full), 0);
    check("t5_fc", int'(frames_captured), 0);
    check("t5_head", int'(ring_head), 0);
    check("t5_err", int'(tlast_err), 0);
    check("t5_rd", int'(rd_data), 0);
    beat(1'b1);
    check("t5_idle_beat", int'(armed), 0);
    check_ram("t5_ram3", 3, base + 3);

    // 6: arm and stop together during CAPTURE
    do_arm(1'b0, 0, 1'b0);
    beat(1'b1);
    frames(1);
    beats(3, 1'b0);
    check("t6_fc_pre", int'(frames_captured), 1);
    do_arm(1'b0, 0, 1'b1);
    check("t6_armed", int'(armed), 1);
    check("t6_fc", int'(frames_captured), 0);
    check("t6_head", int'(ring_head), 0);
    beat(1'b1);
    base = bc;
    frames(1);
    $display("t6 arm+stop: armed=%0d fc=%0d", armed, frames_captured);
    check("t6_no_done", int'(armed), 1);
    check("t6_fc1", int'(frames_captured), 1);
    check_ram("t6_ram0", 0, base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axis_frame_capture.md
Name: axis_frame_capture

Overview:
- Parametrised, synthesizable successor to the simulation-only capture VIP.
- Passively records frame-aligned AXIS samples (OSPFB/FFT output) into on-chip RAM.
- Supports one-shot and ring modes, frame decimation, and tlast integrity checking.
- Readback through a registered read port; sits on the DSP clock after the FFT output, feeding readout logic or a testbench.

Parameters:
- WIDTH, 32, tdata width in bits.
- FRAME_LEN, 512, samples per frame; power of 2, at least 2.
- FRAMES, 32, frames of storage; power of 2, at least 2.
- SKIP_W, 8, width of the decimation control.
- ERR_W, 16, width of the tlast error counter; saturating.

Ports:
- clk  in  1  DSP clock.
- rstn  in  1  synchronous, active-low reset.
- arm  in  1  one-cycle pulse: start or restart a capture.
- stop  in  1  one-cycle pulse: finish the current frame, then go to DONE.
- mode  in  1  capture mode: 0 = ONESHOT, 1 = RING; sampled on arm.
- skip  in  SKIP_W  frames discarded after each captured frame; sampled on arm.
- s_axis_tdata  in  WIDTH  sample data.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tlast  in  1  last sample of a frame.
- s_axis_tready  out  1  tied to 1; the block never backpressures.
- rd_en  in  1  read strobe.
- rd_addr  in  log2(FRAMES*FRAME_LEN)  read address.
- rd_data  out  WIDTH  read data, valid 1 cycle after rd_en.
- armed  out  1  state is SYNC or CAPTURE.
- full  out  1  FRAMES frames are held (ONESHOT done, or RING wrapped).
- frames_captured  out  log2(FRAMES)+1  completed frames; saturates at FRAMES.
- ring_head  out  log2(FRAMES)  index of the oldest frame, equal to the next frame to be written.
- tlast_err  out  ERR_W  count of tlast mismatches.

Behaviour:
- Reset (rstn=0 at a clk edge): state goes to IDLE. armed, full, frames_captured, ring_head, tlast_err and the rd_data register all clear to 0. RAM contents are not cleared. Reset in any state aborts the capture immediately.
- A beat is a cycle with s_axis_tvalid=1; tready is always 1.
- IDLE: arm moves to SYNC.
  - On arm, latch mode and skip; clear full, frames_captured, ring_head, tlast_err, the sample count and the skip count.
- SYNC: discard beats. A beat with tlast=1 moves to CAPTURE; the next beat is sample 0 of frame 0.
- CAPTURE: write addr = {frame_idx, samp_idx} with concatenation, 1 write per beat. Frames marked as skipped still advance samp_idx but are not written.
  - Normal end of frame: a beat with samp_idx==FRAME_LEN-1 and tlast=1.
    - If the frame was written: frame_idx++ (mod FRAMES), frames_captured++ (saturating), then reload the skip count from skip.
    - If the frame was skipped: decrement the skip count.
  - Missing tlast: a beat with samp_idx==FRAME_LEN-1 and tlast=0.
    - tlast_err++; the partial frame is discarded and not counted.
    - Return to SYNC; frame_idx is unchanged, so the frame slot is rewritten.
  - Early tlast: tlast=1 with samp_idx<FRAME_LEN-1. Handle the same as missing tlast, except the next beat is already frame-aligned, so go directly to CAPTURE with samp_idx=0.
  - ONESHOT: when frames_captured reaches FRAMES, go to DONE and set full=1 in the same cycle as the last write commits.
  - RING: frame_idx wraps to 0 and capture continues. full=1 from the first wrap onward.
  - ring_head always equals frame_idx.
- stop in SYNC: go to DONE immediately.
- stop in CAPTURE: set stop_pend. The next normal end of frame (written or skipped) goes to DONE. Missing- or early-tlast events do not clear stop_pend.
- DONE: no writes; status holds. arm moves to SYNC and re-arms as from IDLE.
- arm in SYNC or CAPTURE: abort, and re-arm from SYNC with counters cleared.
- arm and stop in the same cycle: arm wins, and stop_pend clears.
- Read port: registered and read-first. rd_data is updated only when rd_en=1, 1 cycle after it, in any state. A same-address read and write in the same cycle returns the old data.
- Latency: a sample is readable at the rd_addr sampled 1 cycle after its beat (write commits on the beat edge).
- tlast_err saturates at 2^ERR_W-1.

Decomposition:
- Shared package alpaca_capture_pkg holds:
  - typedef enum logic [1:0] {IDLE, SYNC, CAPTURE, DONE} capture_state_t
  - typedef enum logic {ONESHOT, RING} capture_mode_t
  - clog2-derived width localparams
- Sub-module capture_sdp_ram: simple dual-port RAM, depth FRAMES*FRAME_LEN, WIDTH bits, 1 write port, registered read-first read port, inferable as BRAM.

Test Plan (FRAME_LEN=8, FRAMES=4, tdata = running beat count):
1. ONESHOT, skip=0, arm, then 2 junk beats + tlast, then 32 clean beats with tlast every 8th → full=1 on the 32nd beat; frames_captured=4; RAM[k] = first-frame base + k; further beats are not written.
2. RING, skip=0, 6 frames, then stop mid-frame 7 → DONE after frame 7 ends; full=1; ring_head=3; RAM frame 0 holds frame 5 data, frame 2 holds frame 7 data.
3. ONESHOT, skip=2 → the frames written are stream frames 0, 3, 6, 9; full=1 after 10 stream frames.
4. tlast dropped on frame 1's 8th beat, then a good tlast → tlast_err=1; frame slot 1 holds the next clean frame; frames_captured excludes the bad frame. Early tlast at beat 5 → tlast_err=2, and capture resumes next beat without SYNC.
5. rstn=0 for 1 cycle mid-CAPTURE → all outputs 0, IDLE; RAM retains data; rd_en on address 3 returns pre-reset data 1 cycle later.
6. arm and stop in the same cycle during CAPTURE → re-arm in SYNC, counters cleared, no DONE.
